// File: rtl/comparador_arbiter.sv
// Round-robin arbiter sharing one registered 2-bit equality comparator among N_REQ requesters.
// Transaction flow: IDLE (grant + operand capture) -> CMP -> ACK -> REL (wait for req drop).
module comparador_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] a_in,
    input  logic [2*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]   ack,
    output logic               eq_out,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic [7:0]         match_cnt
);

    typedef enum logic [1:0] {IDLE, CMP, ACK, REL} state_t;

    state_t     state, state_n;
    logic [1:0] last_grant;
    logic [1:0] op_a, op_b;
    logic [1:0] sel;
    logic       found;
    logic       eq_cmp;
    logic [3:0] req_pad;
    logic [3:0] ack_q;
    logic [7:0] a_pad, b_pad;

    // Pad to the 4-requester maximum so all indexing stays at fixed 2-bit widths.
    always_comb begin
        req_pad = '0;
        a_pad   = '0;
        b_pad   = '0;
        req_pad[N_REQ-1:0]   = req;
        a_pad[2*N_REQ-1:0]   = a_in;
        b_pad[2*N_REQ-1:0]   = b_in;
    end

    always_comb begin : arbitration
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = {30'b0, last_grant} + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_pad[idx[1:0]]) begin
                found = 1'b1;
                sel   = idx[1:0];
            end
        end
    end

    assign eq_cmp = &(~(op_a ^ op_b));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = CMP;
            CMP:     state_n = ACK;
            ACK:     state_n = REL;
            REL:     if (!req_pad[grant_id]) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // ack is registered from the ACK state, so it is visible the cycle after the ACK edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            grant_id   <= '0;
            last_grant <= 2'(N_REQ - 1);
            eq_out     <= 1'b0;
            match_cnt  <= '0;
            ack_q      <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: if (found) begin
                    grant_id <= sel;
                    op_a     <= a_pad[{sel, 1'b0} +: 2];
                    op_b     <= b_pad[{sel, 1'b0} +: 2];
                end
                CMP: begin
                    eq_out <= eq_cmp;
                    if (eq_cmp && match_cnt != 8'hFF) match_cnt <= match_cnt + 8'd1;
                end
                ACK: begin
                    ack_q[grant_id] <= 1'b1;
                    last_grant      <= grant_id;
                end
                default: ;
            endcase
        end
    end

    assign ack  = ack_q[N_REQ-1:0];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_comparador_arbiter.sv
// Self-checking bench for comparador_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level round-robin model.
module tb_comparador_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] a_in, b_in;
    logic [3:0] ack;
    logic       eq_out;
    logic [1:0] grant_id;
    logic       busy;
    logic [7:0] match_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comparador_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .eq_out(eq_out), .grant_id(grant_id), .busy(busy), .match_cnt(match_cnt)
    );

    task automatic test_reset;
        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        #1;
        checks++; if ({ack, eq_out, grant_id, busy, match_cnt} !== 16'h0) begin errors++; $display("FAIL reset_init: got %h expected 0", {ack, eq_out, grant_id, busy, match_cnt}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; req = 4'b0010; a_in = 8'b0000_1100; b_in = 8'b0000_1100;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL pre_reset_ack: got %b expected 0010", ack); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL pre_reset_gid: got %0d expected 1", grant_id); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL pre_reset_cnt: got %0d expected 1", match_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({ack, eq_out, grant_id, busy, match_cnt} !== 16'h0) begin errors++; $display("FAIL reset_midclock: got %h expected 0", {ack, eq_out, grant_id, busy, match_cnt}); end
        @(negedge clk);
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single;
        req = 4'b0001; a_in = 8'b0000_0010; b_in = 8'b0000_0010;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || ack !== 4'b0) begin errors++; $display("FAIL single_grant: busy %b ack %b expected 1 0000", busy, ack); end
        @(negedge clk);
        checks++; if (eq_out !== 1'b1 || match_cnt !== 8'd1 || ack !== 4'b0) begin errors++; $display("FAIL single_cmp: eq %b cnt %0d ack %b expected 1 1 0000", eq_out, match_cnt, ack); end
        @(negedge clk);
        checks++; if (ack !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL single_ack: ack %b gid %0d expected 0001 0", ack, grant_id); end
        req = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL single_release: busy %b ack %b expected 0 0000", busy, ack); end
    endtask

    task automatic test_mismatch_capture;
        req = 4'b0010; a_in = 8'b0000_0100; b_in = 8'b0000_1100;
        @(negedge clk);
        a_in = 8'b0000_1100;
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL capture_gid: got %0d expected 1", grant_id); end
        @(negedge clk);
        checks++; if (eq_out !== 1'b0 || match_cnt !== 8'd1) begin errors++; $display("FAIL capture_cmp: eq %b cnt %0d expected 0 1", eq_out, match_cnt); end
        @(negedge clk);
        checks++; if (ack !== 4'b0010 || eq_out !== 1'b0) begin errors++; $display("FAIL capture_ack: ack %b eq %b expected 0010 0", ack, eq_out); end
        req = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || eq_out !== 1'b0) begin errors++; $display("FAIL capture_hold: busy %b eq %b expected 0 0", busy, eq_out); end
    endtask

    task automatic test_round_robin;
        int order [5] = '{0, 1, 2, 3, 0};
        int n;
        rst = 1'b1; req = 4'b1111; a_in = 8'hE4; b_in = 8'hE4;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            while (ack == 4'b0 && n < 10) begin @(negedge clk); n++; end
            checks++; if (ack !== 4'(1 << order[j])) begin errors++; $display("FAIL rr_order_%0d: got %b expected %b", j, ack, 4'(1 << order[j])); end
            req[order[j]] = 1'b0;
            @(negedge clk);
            if (j < 4) req[order[j]] = 1'b1;
        end
        req = '0;
        checks++; if (match_cnt !== 8'd5) begin errors++; $display("FAIL rr_count: got %0d expected 5", match_cnt); end
    endtask

    task automatic test_held_req;
        int n;
        req = 4'b0100; a_in = 8'h30; b_in = 8'h30;
        n = 0;
        while (ack == 4'b0 && n < 10) begin @(negedge clk); n++; end
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL held_ack: got %b expected 0100", ack); end
        req = 4'b1101;
        repeat (5) begin
            @(negedge clk);
            checks++; if (busy !== 1'b1 || ack !== 4'b0) begin errors++; $display("FAIL held_rel: busy %b ack %b expected 1 0000", busy, ack); end
        end
        req[2] = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_exit: busy %b expected 0", busy); end
        n = 0;
        while (ack == 4'b0 && n < 10) begin @(negedge clk); n++; end
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL held_next: got %b expected 1000", ack); end
        req = '0;
        n = 0;
        while (busy && n < 10) begin @(negedge clk); n++; end
    endtask

    task automatic test_abort_saturation;
        int n;
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0; req = 4'b0001; a_in = '0; b_in = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || match_cnt !== 8'd0) begin errors++; $display("FAIL abort_reset: busy %b cnt %0d expected 0 0", busy, match_cnt); end
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++; if (ack !== 4'b0) begin errors++; $display("FAIL abort_noack: got %b expected 0000", ack); end
        end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL abort_cnt: got %0d expected 0", match_cnt); end
        for (int i = 0; i < 256; i++) begin
            req = 4'b0001;
            n = 0;
            while (ack == 4'b0 && n < 10) begin @(negedge clk); n++; end
            checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL sat_ack_%0d: got %b expected 0001", i, ack); end
            if (i == 199) begin
                checks++; if (match_cnt !== 8'd200) begin errors++; $display("FAIL sat_mid: got %0d expected 200", match_cnt); end
            end
            req = '0;
            @(negedge clk);
        end
        checks++; if (match_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", match_cnt); end
    endtask

    task automatic test_random;
        int stage, gid_m, last_m, cnt_m, opa, opb, w;
        logic eq_m;
        logic found;
        logic [3:0] ack_m, ack_nxt;
        int hold [4] = '{-1, -1, -1, -1};
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        stage = 0; gid_m = 0; last_m = N - 1; cnt_m = 0; opa = 0; opb = 0; eq_m = 1'b0; ack_m = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++; if (ack !== ack_m) begin errors++; $display("FAIL rand_ack @%0d: got %b expected %b", cyc, ack, ack_m); end
            checks++; if (eq_out !== eq_m) begin errors++; $display("FAIL rand_eq @%0d: got %b expected %b", cyc, eq_out, eq_m); end
            checks++; if (grant_id !== gid_m[1:0]) begin errors++; $display("FAIL rand_gid @%0d: got %0d expected %0d", cyc, grant_id, gid_m); end
            checks++; if (busy !== (stage != 0)) begin errors++; $display("FAIL rand_busy @%0d: got %b expected %b", cyc, busy, stage != 0); end
            checks++; if (match_cnt !== 8'(cnt_m)) begin errors++; $display("FAIL rand_cnt @%0d: got %0d expected %0d", cyc, match_cnt, cnt_m); end
            // Requesters follow the handshake: drop only after their ack, then re-raise at random.
            for (int i = 0; i < N; i++) begin
                if (ack_m[i]) hold[i] = $urandom_range(0, 3);
                if (req[i]) begin
                    if (hold[i] == 0) begin req[i] = 1'b0; hold[i] = -1; end
                    else if (hold[i] > 0) hold[i]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                end
            end
            a_in = 8'($urandom);
            b_in = ($urandom_range(0, 1) == 1) ? a_in : 8'($urandom);
            ack_nxt = '0;
            case (stage)
                0: begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        w = (last_m + k) % N;
                        if (!found && req[w]) begin
                            found = 1'b1;
                            gid_m = w;
                            opa = int'((a_in >> (2 * w)) & 8'h3);
                            opb = int'((b_in >> (2 * w)) & 8'h3);
                        end
                    end
                    if (found) stage = 1;
                end
                1: begin
                    eq_m = (opa == opb);
                    if (eq_m && cnt_m < 255) cnt_m++;
                    stage = 2;
                end
                2: begin
                    ack_nxt[gid_m] = 1'b1;
                    last_m = gid_m;
                    stage = 3;
                end
                default: if (!req[gid_m]) stage = 0;
            endcase
            ack_m = ack_nxt;
            @(negedge clk);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_mismatch_capture();
        test_round_robin();
        test_held_req();
        test_abort_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparador_arbiter.md
COMPARADOR_ARBITER -- requirements
Module: comparador_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the single 2-bit equality comparator (legal 2..4).
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  N_REQ  per-requester comparison request, four-phase handshake.
REQ-005 Port: a_in  input  2*N_REQ  operand A; requester i drives bits [2i+1:2i].
REQ-006 Port: b_in  input  2*N_REQ  operand B; requester i drives bits [2i+1:2i].
REQ-007 Port: ack  output  N_REQ  registered one-hot acknowledge; result valid while high.
REQ-008 Port: eq_out  output  1  registered result: 1 when granted A equals B on both bits.
REQ-009 Port: grant_id  output  2  index of the current or most recent granted requester.
REQ-010 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 Port: match_cnt  output  8  count of comparisons returning equal, saturating.

Function
REQ-012 The block SHALL contain exactly one 2-bit equality comparator, structurally XOR per bit, inverted, ANDed, fed only from internal operand registers.
REQ-013 FSM states SHALL be IDLE, CMP, ACK, REL.
REQ-014 IDLE: if any req bit high, SHALL select the winner by round-robin starting at (last_grant+1) mod N_REQ, latch its A/B into operand registers, load grant_id, go to CMP; otherwise stay in IDLE.
REQ-015 CMP: SHALL register the comparator output into eq_out, go to ACK.
REQ-016 ACK: SHALL drive ack[grant_id]=1 for exactly one cycle, with all other ack bits 0; eq_out valid in this cycle; last_grant SHALL update to grant_id; go to REL.
REQ-017 REL: SHALL remain while req[grant_id]=1; SHALL go to IDLE on the first edge where req[grant_id]=0.
REQ-018 Latency: req sampled high in IDLE at edge k -> ack high during the cycle following edge k+2; fixed, independent of operand values.
REQ-019 Operands SHALL be captured only at the grant edge; later a_in/b_in changes SHALL NOT affect the current result.
REQ-020 Requests from non-granted requesters SHALL be held pending, never dropped, never served out of round-robin order.
REQ-021 A requester re-asserting req after its own REL SHALL be served only after every other pending requester, in order.
REQ-022 eq_out SHALL hold its value from the last ACK until the next CMP->ACK transition.
REQ-023 match_cnt SHALL increment by 1 on the CMP->ACK edge when the comparator output is 1, and SHALL saturate at 255.
REQ-024 req bits at index >= N_REQ do not exist; grant_id SHALL never exceed N_REQ-1.

Reset
REQ-025 rst=1 SHALL immediately, regardless of clk, force FSM=IDLE, ack=0, eq_out=0, grant_id=0, busy=0, match_cnt=0, operand registers=0, last_grant=N_REQ-1.
REQ-026 Reset asserted in CMP, ACK or REL SHALL abort the transaction with no ack pulse and no match_cnt update.
REQ-027 After rst deasserts, the first grant SHALL go to the lowest-indexed pending requester.

Verification
REQ-028 Reset: assert rst mid-clock -> all outputs 0 immediately, before the next edge.
REQ-029 Single request: req[0]=1, A0=2'b10, B0=2'b10 -> ack=4'b0001 two edges after sampling, eq_out=1, match_cnt=1; drop req -> busy=0 one edge later.
REQ-030 Mismatch and capture: req[1]=1, A1=2'b01, B1=2'b11, change A1 to 2'b11 after grant -> eq_out=0, match_cnt unchanged.
REQ-031 Round-robin: req=4'b1111 held from reset, each dropped after its ack and re-raised -> grant order 0,1,2,3,0.
REQ-032 Held req: req[2] kept high for 5 cycles after ack -> FSM stays in REL, busy=1, no other ack until req[2] drops.
REQ-033 Abort and saturation: rst pulsed in CMP -> no ack, match_cnt=0; then 256 equal comparisons -> match_cnt=255.
